t03_mem_request_arbiter: RTL
============================

T03_MEM_REQUEST_ARBITER -- requirements
Module: t03_mem_request_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width.
REQ-002 Parameter DATA_W, default 32: data width; SHALL be a multiple of 8.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for ack; 0 disables the timeout.
REQ-004 Port clk, in, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, in, 1: reset; synchronous, active-high.
REQ-006 Port ack, in, 1: bus acknowledge; completes the current access in the cycle it is high.
REQ-007 Port bus_rdata, in, DATA_W: bus read data; valid when ack=1.
REQ-008 Port mem_read, in, 1: decoded load request.
REQ-009 Port mem_write, in, 1: decoded store request.
REQ-010 Port pc, in, ADDR_W: fetch address.
REQ-011 Port alu_addr, in, ADDR_W: load/store address.
REQ-012 Port store_data, in, DATA_W: store data.
REQ-013 Port byte_en, in, DATA_W/8: store byte lanes.
REQ-014 Port err_clr, in, 1: clears timeout_err.
REQ-015 Port bus_read, out, 1: bus read strobe.
REQ-016 Port bus_write, out, 1: bus write strobe.
REQ-017 Port bus_addr, out, ADDR_W: bus address.
REQ-018 Port bus_wdata, out, DATA_W: bus write data.
REQ-019 Port bus_sel, out, DATA_W/8: bus byte select.
REQ-020 Port freeze_pc, out, 1: PC hold.
REQ-021 Port freeze_instr, out, 1: pipeline hold.
REQ-022 Port instr, out, DATA_W: registered fetched instruction.
REQ-023 Port load_data, out, DATA_W: registered load result.
REQ-024 Port load_valid, out, 1: one-cycle pulse when load_data updates.
REQ-025 Port timeout_err, out, 1: sticky timeout flag.

Function
REQ-026 The FSM SHALL have four states: FETCH, DECIDE, DREAD, DWRITE.
REQ-027 FETCH: bus_read=1, bus_addr=pc, bus_sel all ones; on ack, instr<=bus_rdata, freeze_pc=0 in that cycle only, next state DECIDE.
REQ-028 DECIDE: lasts one cycle, with no bus strobes and freeze_instr=0; next state is DREAD if mem_read, else DWRITE if mem_write, else FETCH.
REQ-029 If mem_read and mem_write are both high in DECIDE, the read SHALL win.
REQ-030 DREAD: bus_read=1, bus_addr=alu_addr, bus_sel all ones; on ack, load_data<=bus_rdata, load_valid=1 next cycle, next state FETCH.
REQ-031 DWRITE: bus_write=1, bus_addr=alu_addr, bus_wdata=store_data, bus_sel=byte_en; on ack, next state FETCH.
REQ-032 Outside DWRITE: bus_wdata=0; outside FETCH/DREAD/DWRITE: bus_addr=pc and bus_sel=0.
REQ-033 freeze_pc=1 in all cycles except a FETCH cycle with ack=1.
REQ-034 freeze_instr=1 in all states except DECIDE.
REQ-035 bus_read and bus_write SHALL never be high together.
REQ-036 A wait counter of width clog2(TIMEOUT+1) SHALL clear on every state change and increment each bus-state cycle with ack=0.
REQ-037 If TIMEOUT>0 and the counter equals TIMEOUT-1 with ack=0, the access SHALL abort: timeout_err<=1; from DREAD/DWRITE go to FETCH with load_data unchanged and no load_valid; from FETCH stay in FETCH, restart the counter and retry the same pc.
REQ-038 ack arriving in the abort cycle SHALL take precedence: the access completes normally and no error is set.
REQ-039 err_clr SHALL clear timeout_err next cycle; if a timeout occurs in the same cycle, set wins.
REQ-040 An ack seen in DECIDE SHALL be ignored.
REQ-041 A load completes after at least 3 cycles: FETCH ack -> DECIDE -> DREAD ack.

Reset
REQ-042 While rst=1 at a clock edge: state<=FETCH, counter<=0, instr<=0, load_data<=0, load_valid<=0, timeout_err<=0.
REQ-043 In the first cycle after reset the outputs SHALL be bus_read=1, bus_write=0, bus_addr=pc, freeze_pc=1, freeze_instr=1.
REQ-044 rst mid-access SHALL abandon the access without completion side effects; the pending ack is ignored.

Verification
REQ-045 Non-memory instruction: pc=0x100, ack on 1st fetch cycle, bus_rdata=0x00000013, mem_read=mem_write=0 -> instr=0x13, DECIDE for 1 cycle, back in FETCH; freeze_pc low for exactly 1 cycle.
REQ-046 Load: alu_addr=0x2000, ack after 2 wait cycles with bus_rdata=0xDEADBEEF -> bus_addr=0x2000 during DREAD, load_data=0xDEADBEEF, load_valid pulses once.
REQ-047 Store: store_data=0xA5A5A5A5, byte_en=4'b0011 -> bus_write=1, bus_sel=0011, bus_wdata=0xA5A5A5A5 until ack, then FETCH.
REQ-048 Timeout: TIMEOUT=4, DREAD with no ack -> abort after 4 cycles, timeout_err=1, load_data unchanged; err_clr -> 0; with ack in the abort cycle -> no error.
REQ-049 Conflict and reset: mem_read=mem_write=1 -> DREAD taken; rst asserted in DWRITE with ack=1 -> FETCH, all registers reset.
REQ-050 Every test SHALL check that bus_read and bus_write are never high together.

Source files
------------

// File: rtl/t03_mem_request_arbiter_if.sv
// t03_mem_request_arbiter_if: bus and pipeline signals between the core and the memory request arbiter.
interface t03_mem_request_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                ack;
    logic [DATA_W-1:0]   bus_rdata;
    logic                mem_read;
    logic                mem_write;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   alu_addr;
    logic [DATA_W-1:0]   store_data;
    logic [DATA_W/8-1:0] byte_en;
    logic                err_clr;
    logic                bus_read;
    logic                bus_write;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_sel;
    logic                freeze_pc;
    logic                freeze_instr;
    logic [DATA_W-1:0]   instr;
    logic [DATA_W-1:0]   load_data;
    logic                load_valid;
    logic                timeout_err;

    modport slave (
        input  ack, bus_rdata, mem_read, mem_write, pc, alu_addr, store_data, byte_en, err_clr,
        output bus_read, bus_write, bus_addr, bus_wdata, bus_sel, freeze_pc, freeze_instr,
               instr, load_data, load_valid, timeout_err
    );

    modport master (
        output ack, bus_rdata, mem_read, mem_write, pc, alu_addr, store_data, byte_en, err_clr,
        input  bus_read, bus_write, bus_addr, bus_wdata, bus_sel, freeze_pc, freeze_instr,
               instr, load_data, load_valid, timeout_err
    );
endinterface

// File: rtl/t03_mem_request_arbiter.sv
// t03_mem_request_arbiter: shares one memory bus between instruction fetch and load/store, with ack timeout.
module t03_mem_request_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic clk,
    input logic rst,
    t03_mem_request_arbiter_if.slave bus
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {FETCH, DECIDE, DREAD, DWRITE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] load_q, load_d;
    logic              lv_q, lv_d;
    logic              err_q, err_d;
    logic              in_bus;
    logic              abort;

    always_comb begin
        in_bus  = state_q != DECIDE;
        // a late ack in the abort cycle still completes the access
        abort   = (TIMEOUT > 0) && in_bus && !bus.ack && cnt_q == LAST;
        state_d = state_q;
        instr_d = instr_q;
        load_d  = load_q;
        lv_d    = 1'b0;
        case (state_q)
            FETCH: begin
                if (bus.ack) begin
                    instr_d = bus.bus_rdata;
                    state_d = DECIDE;
                end
            end
            DECIDE: state_d = bus.mem_read ? DREAD : bus.mem_write ? DWRITE : FETCH;
            DREAD: begin
                if (bus.ack) begin
                    load_d  = bus.bus_rdata;
                    lv_d    = 1'b1;
                    state_d = FETCH;
                end else if (abort) begin
                    state_d = FETCH;
                end
            end
            DWRITE: state_d = (bus.ack || abort) ? FETCH : DWRITE;
        endcase
        cnt_d = (state_d != state_q || abort) ? '0 : (in_bus && !bus.ack) ? cnt_q + 1'b1 : cnt_q;
        err_d = abort | (err_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
            instr_q <= '0;
            load_q  <= '0;
            lv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            load_q  <= load_d;
            lv_q    <= lv_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_read     = state_q == FETCH || state_q == DREAD;
    assign bus.bus_write    = state_q == DWRITE;
    assign bus.bus_addr     = (state_q == DREAD || state_q == DWRITE) ? bus.alu_addr : bus.pc;
    assign bus.bus_wdata    = state_q == DWRITE ? bus.store_data : '0;
    assign bus.bus_sel      = state_q == DECIDE ? '0 : state_q == DWRITE ? bus.byte_en : '1;
    assign bus.freeze_pc    = !(state_q == FETCH && bus.ack);
    assign bus.freeze_instr = state_q != DECIDE;
    assign bus.instr        = instr_q;
    assign bus.load_data    = load_q;
    assign bus.load_valid   = lv_q;
    assign bus.timeout_err  = err_q;
endmodule
